alarm_ring_ctrl: RTL and testbench
==================================

Name: alarm_ring_ctrl

Overview:
Sequences the alarm output stage: turns the alarm-time match level into a ringing session with a beep pattern, snooze handling, a snooze limit and an auto-timeout. Sits between the alarm-time comparator (match level, alarm-enable) and the buzzer pin and status LEDs. Consumes the shared 1 Hz and tone tick pulses from the clock-divider tree, so it has no large prescaler of its own.

Parameters:
RING_SEC, 60, number of sec_tick pulses a ring session lasts before auto-stop
SNOOZE_SEC, 300, number of sec_tick pulses in a snooze interval
MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
alarm_on  input  1  alarm armed (level); low forces IDLE
alarm_match  input  1  level, high while current time equals alarm time
btn_snooze  input  1  debounced one-cycle pulse
btn_stop  input  1  debounced one-cycle pulse
sec_tick  input  1  one-cycle pulse, 1 Hz
tone_tick  input  1  one-cycle pulse at 2x buzzer tone frequency
buzzer  output  1  square-wave drive, registered
ringing  output  1  high in RING
snoozing  output  1  high in SNOOZE
snooze_cnt  output  2  snoozes used in current event

Behaviour:
- Reset: state=IDLE; buzzer, ringing, snoozing, snooze_cnt, timer, beep_phase, match_d all 0.
- match_d registers alarm_match. trigger = alarm_match & ~match_d & alarm_on. The rising edge is the only trigger, so a match level that persists for a minute after a stop does not retrigger.
- Timer: width $clog2(max(RING_SEC,SNOOZE_SEC)+1). Cleared on every state entry. Increments on sec_tick. Expiry = sec_tick & (timer==N-1), i.e. exactly N sec_ticks after entry.
- States:
  - IDLE: trigger -> RING, snooze_cnt=0.
  - RING: btn_stop -> IDLE, snooze_cnt=0. btn_snooze & snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1. btn_snooze at the limit is ignored and RING continues with the timer unchanged. Expiry(RING_SEC) -> IDLE, snooze_cnt=0.
  - SNOOZE: btn_stop -> IDLE, snooze_cnt=0. Expiry(SNOOZE_SEC) -> RING with snooze_cnt held. btn_snooze is ignored.
- Any state: alarm_on low -> IDLE next cycle, snooze_cnt=0. This has priority over everything.
- Priority: ~alarm_on > btn_stop > btn_snooze > timer expiry > trigger.
- A trigger in RING or SNOOZE is ignored and the timer is not restarted.
- ringing and snoozing are registered decodes of the next state, so they are valid the cycle after the transition. They are never both high.
- Beep pattern:
  - beep_phase is set to 1 on RING entry and toggles on each sec_tick while in RING, giving 1 s on / 1 s off.
  - buzzer toggles on tone_tick when RING & beep_phase; otherwise it is forced to 0 the next cycle.
  - Leaving RING drops buzzer to 0 within 1 cycle.
- A sec_tick in the same cycle as a button press: the button transition wins and the tick is not counted toward the new state's timer.

Decomposition:
- defines.v gains the 2-bit state encodings `AL_IDLE=0, `AL_RING=1, `AL_SNOOZE=2. The FSM case statement uses these constants.
- One natural sub-module, beep_gen. Inputs: clk, reset, enable, sec_tick, tone_tick. Output: buzzer. It holds beep_phase and the tone flip-flop and restarts phase=1 on the enable rising edge.
- The FSM, timer and edge detect stay in alarm_ring_ctrl.

Test Plan (RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2):
1. Arm (alarm_on=1) and raise alarm_match -> ringing=1 the cycle after the edge. Buzzer toggles on tone_tick during seconds 1 and 3 and is silent in seconds 2 and 4. After the 4th sec_tick: IDLE, ringing=0, buzzer=0. alarm_match held high afterwards -> no retrigger.
2. Trigger, then btn_snooze after 1 sec_tick -> snoozing=1, snooze_cnt=1, buzzer=0. After 3 sec_ticks -> ringing=1 again, snooze_cnt=1.
3. Snooze twice (snooze_cnt=2), then a third btn_snooze in RING -> ignored: stays RING, snooze_cnt=2, auto-stop still occurs after 4 sec_ticks.
4. btn_stop and btn_snooze in the same cycle while RING -> IDLE, snooze_cnt=0.
5. Drop alarm_on mid-SNOOZE -> IDLE next cycle, snoozing=0. Re-arm with alarm_match still high -> no ring until alarm_match falls and rises again.
6. Assert reset mid-RING with buzzer=1 -> all outputs 0 immediately (asynchronous). After release, state is IDLE.

Source files
------------

// File: rtl/alarm_ring_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alarm_ring_ctrl_pkg
// Shared constants for the alarm output stage: the 2-bit FSM state codes
// and a small helper used to size the session timer.
// ---------------------------------------------------------------------------
package alarm_ring_ctrl_pkg;

   // FSM state encodings (kept as plain 2-bit constants for legacy users)
   localparam logic [1:0] AL_IDLE   = 2'd0;
   localparam logic [1:0] AL_RING   = 2'd1;
   localparam logic [1:0] AL_SNOOZE = 2'd2;

   // Larger of two integers, used to size the shared ring/snooze timer
   function automatic int max_of(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/alarm_ring_ctrl_beep_gen.sv
// ---------------------------------------------------------------------------
// alarm_ring_ctrl_beep_gen
// Produces the buzzer square wave while ringing: 1 s on / 1 s off cadence
// driven by sec_tick, tone toggled by tone_tick during the "on" seconds.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   enable    high while the alarm is (about to be) in RING
//   sec_tick  1 Hz one-cycle pulse
//   tone_tick one-cycle pulse at 2x the tone frequency
//   buzzer    registered buzzer drive
// ---------------------------------------------------------------------------
module alarm_ring_ctrl_beep_gen (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic sec_tick,
   input  logic tone_tick,
   output logic buzzer
);

   logic en_d_r;
   logic phase_r;
   logic buzzer_r;
   logic rise_s;

   // A new ring session always starts with an audible second
   assign rise_s = enable & ~en_d_r;

   // Cadence phase and tone flip-flop; silent whenever not enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_d_r   <= 1'b0;
         phase_r  <= 1'b0;
         buzzer_r <= 1'b0;
      end else begin
         en_d_r <= enable;
         if (!enable) begin
            phase_r  <= 1'b0;
            buzzer_r <= 1'b0;
         end else if (rise_s) begin
            phase_r  <= 1'b1;
            buzzer_r <= 1'b0;
         end else begin
            if (sec_tick) begin
               phase_r <= ~phase_r;
            end else begin
               phase_r <= phase_r;
            end
            // tone uses the phase of the current second, so the last
            // tone edge of an "on" second is still honoured
            if (phase_r) begin
               if (tone_tick) begin
                  buzzer_r <= ~buzzer_r;
               end else begin
                  buzzer_r <= buzzer_r;
               end
            end else begin
               buzzer_r <= 1'b0;
            end
         end
      end
   end

   assign buzzer = buzzer_r;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ring_ctrl
// Turns the alarm-time match level into a ringing session with snooze
// handling, a per-event snooze limit and an auto-timeout.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   alarm_on     alarm armed level; low forces IDLE
//   alarm_match  high while current time equals alarm time
//   btn_snooze   debounced one-cycle snooze press
//   btn_stop     debounced one-cycle stop press
//   sec_tick     1 Hz one-cycle pulse
//   tone_tick    one-cycle pulse at 2x buzzer tone frequency
//   buzzer       registered square-wave drive
//   ringing      high in RING
//   snoozing     high in SNOOZE
//   snooze_cnt   snoozes used in the current alarm event
// ---------------------------------------------------------------------------
module alarm_ring_ctrl
   import alarm_ring_ctrl_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       alarm_on,
   input  logic       alarm_match,
   input  logic       btn_snooze,
   input  logic       btn_stop,
   input  logic       sec_tick,
   input  logic       tone_tick,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);

   localparam int TW = $clog2(max_of(RING_SEC, SNOOZE_SEC) + 1);
   localparam logic [TW-1:0] RING_LAST   = TW'(RING_SEC - 1);
   localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SEC - 1);
   localparam logic [1:0]    SNOOZE_LIM  = 2'(MAX_SNOOZE);

   logic [1:0]    state_r;
   logic [1:0]    state_nxt_s;
   logic          match_d_r;
   logic [TW-1:0] timer_r;
   logic [1:0]    cnt_r;
   logic [1:0]    cnt_nxt_s;
   logic          ringing_r;
   logic          snoozing_r;
   logic          trigger_s;
   logic          ring_exp_s;
   logic          snooze_exp_s;
   logic          ring_en_s;

   // Only the rising edge of the match level starts an event, so a match
   // that is still high after a stop does not ring again
   assign trigger_s    = alarm_match & ~match_d_r & alarm_on;
   assign ring_exp_s   = sec_tick & (timer_r == RING_LAST);
   assign snooze_exp_s = sec_tick & (timer_r == SNOOZE_LAST);

   // Next-state and snooze-count decision, in priority order
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (!alarm_on) begin
         state_nxt_s = AL_IDLE;
         cnt_nxt_s   = 2'd0;
      end else begin
         case (state_r)
            AL_IDLE: begin
               if (trigger_s) begin
                  state_nxt_s = AL_RING;
                  cnt_nxt_s   = 2'd0;
               end else begin
                  state_nxt_s = AL_IDLE;
               end
            end
            AL_RING: begin
               if (btn_stop) begin
                  state_nxt_s = AL_IDLE;
                  cnt_nxt_s   = 2'd0;
               end else if (btn_snooze && (cnt_r < SNOOZE_LIM)) begin
                  state_nxt_s = AL_SNOOZE;
                  cnt_nxt_s   = cnt_r + 2'd1;
               end else if (ring_exp_s) begin
                  state_nxt_s = AL_IDLE;
                  cnt_nxt_s   = 2'd0;
               end else begin
                  state_nxt_s = AL_RING;
               end
            end
            AL_SNOOZE: begin
               if (btn_stop) begin
                  state_nxt_s = AL_IDLE;
                  cnt_nxt_s   = 2'd0;
               end else if (snooze_exp_s) begin
                  state_nxt_s = AL_RING;
               end else begin
                  state_nxt_s = AL_SNOOZE;
               end
            end
            default: begin
               state_nxt_s = AL_IDLE;
               cnt_nxt_s   = 2'd0;
            end
         endcase
      end
   end

   // State, counters and registered status decodes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= AL_IDLE;
         match_d_r  <= 1'b0;
         timer_r    <= '0;
         cnt_r      <= 2'd0;
         ringing_r  <= 1'b0;
         snoozing_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         match_d_r  <= alarm_match;
         cnt_r      <= cnt_nxt_s;
         ringing_r  <= (state_nxt_s == AL_RING);
         snoozing_r <= (state_nxt_s == AL_SNOOZE);
         // any transition restarts the timer and swallows a coincident tick
         if (state_nxt_s != state_r) begin
            timer_r <= '0;
         end else if (sec_tick && (state_r != AL_IDLE)) begin
            timer_r <= timer_r + TW'(1);
         end else begin
            timer_r <= timer_r;
         end
      end
   end

   assign ring_en_s = (state_nxt_s == AL_RING);

   alarm_ring_ctrl_beep_gen u_beep_gen (
      .clk       (clk),
      .reset     (reset),
      .enable    (ring_en_s),
      .sec_tick  (sec_tick),
      .tone_tick (tone_tick),
      .buzzer    (buzzer)
   );

   assign ringing    = ringing_r;
   assign snoozing   = snoozing_r;
   assign snooze_cnt = cnt_r;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_ring_ctrl
// Directed bench for alarm_ring_ctrl with RING_SEC=4, SNOOZE_SEC=3,
// MAX_SNOOZE=2. Inputs change 1 ns after a rising edge; outputs are read
// at that same point, i.e. they show the effect of the preceding edge.
// ---------------------------------------------------------------------------
module tb_alarm_ring_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       alarm_on;
   logic       alarm_match;
   logic       btn_snooze;
   logic       btn_stop;
   logic       sec_tick;
   logic       tone_tick;
   logic       buzzer;
   logic       ringing;
   logic       snoozing;
   logic [1:0] snooze_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   alarm_ring_ctrl #(
      .RING_SEC   (4),
      .SNOOZE_SEC (3),
      .MAX_SNOOZE (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .alarm_on    (alarm_on),
      .alarm_match (alarm_match),
      .btn_snooze  (btn_snooze),
      .btn_stop    (btn_stop),
      .sec_tick    (sec_tick),
      .tone_tick   (tone_tick),
      .buzzer      (buzzer),
      .ringing     (ringing),
      .snoozing    (snoozing),
      .snooze_cnt  (snooze_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vec_cnt++;
      if (obs !== exp_v) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_sec();
      sec_tick = 1'b1;
      cyc(1);
      sec_tick = 1'b0;
   endtask

   task automatic pulse_tone();
      tone_tick = 1'b1;
      cyc(1);
      tone_tick = 1'b0;
   endtask

   task automatic pulse_snooze();
      btn_snooze = 1'b1;
      cyc(1);
      btn_snooze = 1'b0;
   endtask

   // Produce a fresh rising edge on alarm_match
   task automatic trigger_alarm();
      alarm_match = 1'b0;
      cyc(1);
      alarm_match = 1'b1;
      cyc(1);
   endtask

   initial begin
      reset       = 1'b1;
      alarm_on    = 1'b0;
      alarm_match = 1'b0;
      btn_snooze  = 1'b0;
      btn_stop    = 1'b0;
      sec_tick    = 1'b0;
      tone_tick   = 1'b0;
      cyc(2);
      check_val("rst_buzzer",   {31'd0, buzzer},   32'd0);
      check_val("rst_ringing",  {31'd0, ringing},  32'd0);
      check_val("rst_snoozing", {31'd0, snoozing}, 32'd0);
      check_val("rst_cnt",      {30'd0, snooze_cnt}, 32'd0);
      reset = 1'b0;
      cyc(2);

      // 1: ring with beep cadence, auto-stop after 4 s, no retrigger
      alarm_on    = 1'b1;
      alarm_match = 1'b1;
      cyc(1);
      check_val("t1_ringing", {31'd0, ringing},  32'd1);
      check_val("t1_cnt",     {30'd0, snooze_cnt}, 32'd0);
      pulse_tone();
      check_val("t1_s1_tone1", {31'd0, buzzer}, 32'd1);
      pulse_tone();
      check_val("t1_s1_tone2", {31'd0, buzzer}, 32'd0);
      pulse_tone();
      pulse_sec();
      cyc(1);
      check_val("t1_s2_silent", {31'd0, buzzer}, 32'd0);
      pulse_tone();
      check_val("t1_s2_tone", {31'd0, buzzer}, 32'd0);
      pulse_sec();
      pulse_tone();
      check_val("t1_s3_tone", {31'd0, buzzer}, 32'd1);
      pulse_sec();
      check_val("t1_after3", {31'd0, ringing}, 32'd1);
      pulse_sec();
      check_val("t1_exp_ringing", {31'd0, ringing}, 32'd0);
      check_val("t1_exp_buzzer",  {31'd0, buzzer},  32'd0);
      cyc(5);
      check_val("t1_no_retrig", {31'd0, ringing}, 32'd0);

      // 2: snooze after one second, ring again after 3 s of snooze
      trigger_alarm();
      check_val("t2_ringing", {31'd0, ringing}, 32'd1);
      pulse_sec();
      pulse_snooze();
      check_val("t2_snoozing", {31'd0, snoozing}, 32'd1);
      check_val("t2_ring_off", {31'd0, ringing},  32'd0);
      check_val("t2_cnt",      {30'd0, snooze_cnt}, 32'd1);
      check_val("t2_buzzer",   {31'd0, buzzer},   32'd0);
      pulse_sec();
      pulse_sec();
      check_val("t2_still_snz", {31'd0, snoozing}, 32'd1);
      pulse_sec();
      check_val("t2_reringing", {31'd0, ringing},  32'd1);
      check_val("t2_snz_off",   {31'd0, snoozing}, 32'd0);
      check_val("t2_cnt_held",  {30'd0, snooze_cnt}, 32'd1);

      // 3: second snooze, then a third press at the limit is ignored
      pulse_snooze();
      check_val("t3_cnt2", {30'd0, snooze_cnt}, 32'd2);
      pulse_sec();
      pulse_sec();
      pulse_sec();
      check_val("t3_ring", {31'd0, ringing}, 32'd1);
      pulse_snooze();
      check_val("t3_lim_ring", {31'd0, ringing},  32'd1);
      check_val("t3_lim_snz",  {31'd0, snoozing}, 32'd0);
      check_val("t3_lim_cnt",  {30'd0, snooze_cnt}, 32'd2);
      pulse_sec();
      pulse_sec();
      pulse_sec();
      check_val("t3_before_exp", {31'd0, ringing}, 32'd1);
      pulse_sec();
      check_val("t3_exp_ring", {31'd0, ringing}, 32'd0);
      check_val("t3_exp_cnt",  {30'd0, snooze_cnt}, 32'd0);

      // 4: stop and snooze together while buzzing -> IDLE
      trigger_alarm();
      pulse_tone();
      check_val("t4_buzz_on", {31'd0, buzzer}, 32'd1);
      btn_stop   = 1'b1;
      btn_snooze = 1'b1;
      cyc(1);
      btn_stop   = 1'b0;
      btn_snooze = 1'b0;
      check_val("t4_ringing",  {31'd0, ringing},  32'd0);
      check_val("t4_snoozing", {31'd0, snoozing}, 32'd0);
      check_val("t4_cnt",      {30'd0, snooze_cnt}, 32'd0);
      check_val("t4_buzzer",   {31'd0, buzzer},   32'd0);

      // 5: disarm mid-snooze, re-arm with match still high
      trigger_alarm();
      pulse_snooze();
      check_val("t5_snoozing", {31'd0, snoozing}, 32'd1);
      alarm_on = 1'b0;
      cyc(1);
      check_val("t5_off_snz", {31'd0, snoozing}, 32'd0);
      check_val("t5_off_cnt", {30'd0, snooze_cnt}, 32'd0);
      alarm_on = 1'b1;
      cyc(3);
      check_val("t5_rearm_quiet", {31'd0, ringing}, 32'd0);
      trigger_alarm();
      check_val("t5_new_edge", {31'd0, ringing}, 32'd1);

      // 6: asynchronous reset while buzzing
      pulse_tone();
      check_val("t6_buzz_on", {31'd0, buzzer}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_val("t6_async_buzzer",  {31'd0, buzzer},  32'd0);
      check_val("t6_async_ringing", {31'd0, ringing}, 32'd0);
      alarm_match = 1'b0;
      cyc(1);
      reset = 1'b0;
      cyc(2);
      check_val("t6_idle_ring", {31'd0, ringing},  32'd0);
      check_val("t6_idle_snz",  {31'd0, snoozing}, 32'd0);
      check_val("t6_idle_buzz", {31'd0, buzzer},   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
